// File: rtl/iir_tdm_pkg.sv
// Shared types and helpers for the time-division IIR scheduler.
package iir_tdm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int clog2m1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iir_tdm_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after 'last', wrapping.
module rr_arbiter
  import iir_tdm_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2m1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          en,
  output logic          grant_valid,
  output logic [IW-1:0] grant
);

  int idx;

  // Walk candidates from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (en && req[IW'(idx)]) begin
        grant_valid = 1'b1;
        grant       = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/iir_tdm_ctrl.sv
// Shares one external SOS engine across CH channels, NS sections each.
module iir_tdm_ctrl
  import iir_tdm_pkg::*;
#(
  parameter  int CH = 4,
  parameter  int NS = 3,
  parameter  int DW = 10,
  localparam int CW = clog2m1(CH),
  localparam int SW = clog2m1(NS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CH-1:0]    in_valid,
  input  logic [CH*DW-1:0] in_data,
  output logic             sos_start,
  output logic [CW-1:0]    sos_ch,
  output logic [SW-1:0]    sos_sec,
  output logic [DW-1:0]    sos_x,
  input  logic             sos_done,
  input  logic [DW-1:0]    sos_y,
  output logic             out_valid,
  output logic [CW-1:0]    out_ch,
  output logic [DW-1:0]    out_data,
  output logic [CH-1:0]    overrun
);

  localparam logic [SW-1:0] SEC_LAST = SW'(NS - 1);

  state_t                 st, st_nxt;
  logic [CH-1:0]          pend, pend_nxt;
  logic [CH-1:0]          ovr_nxt;
  logic [CH-1:0][DW-1:0]  smp, smp_nxt;
  logic [CW-1:0]          last_g, cur, cur_nxt, gnt;
  logic [SW-1:0]          sec, sec_nxt;
  logic [DW-1:0]          x, x_nxt;
  logic                   gnt_vld;

  // Grants are only considered while idle and enabled.
  rr_arbiter #(.N(CH)) u_arb (
    .req         (pend),
    .last        (last_g),
    .en          (en && (st == IDLE)),
    .grant_valid (gnt_vld),
    .grant       (gnt)
  );

  // Pending slots: a fresh sample always wins; a grant in the same cycle
  // consumes the old sample, so that case is not counted as an overrun.
  always_comb begin
    pend_nxt = pend;
    ovr_nxt  = overrun;
    smp_nxt  = smp;
    for (int i = 0; i < CH; i++) begin
      if (in_valid[i]) begin
        smp_nxt[i]  = in_data[i*DW +: DW];
        pend_nxt[i] = 1'b1;
        if (pend[i] && !(gnt_vld && (gnt == CW'(i))))
          ovr_nxt[i] = 1'b1;
      end else if (gnt_vld && (gnt == CW'(i))) begin
        pend_nxt[i] = 1'b0;
      end
    end
  end

  // Slot storage and sticky overrun flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= '0;
      overrun <= '0;
      smp     <= '0;
    end else begin
      pend    <= pend_nxt;
      overrun <= ovr_nxt;
      smp     <= smp_nxt;
    end
  end

  // Next-state and job-context update; x carries the running section value.
  always_comb begin
    st_nxt  = st;
    cur_nxt = cur;
    sec_nxt = sec;
    x_nxt   = x;
    unique case (st)
      IDLE: begin
        if (gnt_vld) begin
          st_nxt  = ISSUE;
          cur_nxt = gnt;
          sec_nxt = '0;
          x_nxt   = smp[gnt];
        end
      end
      ISSUE: st_nxt = WAIT;
      WAIT: begin
        if (sos_done) begin
          x_nxt = sos_y;
          if (sec == SEC_LAST) begin
            st_nxt = OUT;
          end else begin
            sec_nxt = sec + SW'(1);
            st_nxt  = ISSUE;
          end
        end
      end
      OUT:     st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  // Job context and outputs; outputs are loaded from next-state values so
  // they line up with the ISSUE/OUT states while still being registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= '0;
      sec       <= '0;
      x         <= '0;
      last_g    <= CW'(CH - 1);
      sos_start <= 1'b0;
      sos_ch    <= '0;
      sos_sec   <= '0;
      sos_x     <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else begin
      cur       <= cur_nxt;
      sec       <= sec_nxt;
      x         <= x_nxt;
      sos_start <= (st_nxt == ISSUE);
      out_valid <= (st_nxt == OUT);
      if (st_nxt == ISSUE) begin
        sos_ch  <= cur_nxt;
        sos_sec <= sec_nxt;
        sos_x   <= x_nxt;
      end
      if (st_nxt == OUT) begin
        out_ch   <= cur_nxt;
        out_data <= x_nxt;
      end
      if (st == OUT) last_g <= cur;
    end
  end

endmodule

// File: tb/tb_iir_tdm_ctrl.sv
// Bench for iir_tdm_ctrl with a +1 stub engine of latency L.
module tb_iir_tdm_ctrl;

  localparam int CH = 4;
  localparam int NS = 3;
  localparam int DW = 10;
  localparam int CW = 2;
  localparam int SW = 2;
  localparam int L  = 3;

  typedef struct {
    int ch;
    int data;
    int cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [CH-1:0]    in_valid = '0;
  logic [CH*DW-1:0] in_data = '0;
  logic             sos_start;
  logic [CW-1:0]    sos_ch;
  logic [SW-1:0]    sos_sec;
  logic [DW-1:0]    sos_x;
  logic             sos_done = 1'b0;
  logic [DW-1:0]    sos_y = '0;
  logic             out_valid;
  logic [CW-1:0]    out_ch;
  logic [DW-1:0]    out_data;
  logic [CH-1:0]    overrun;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  int          stub_cnt = 0;
  logic [DW-1:0] stub_y = '0;

  iir_tdm_ctrl #(.CH(CH), .NS(NS), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .sos_start (sos_start),
    .sos_ch    (sos_ch),
    .sos_sec   (sos_sec),
    .sos_x     (sos_x),
    .sos_done  (sos_done),
    .sos_y     (sos_y),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Stub engine: done is seen by the DUT at the end of cycle t+L, y = x+1.
  always @(negedge clk) begin
    sos_done = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        sos_done = 1'b1;
        sos_y    = stub_y;
      end
    end
    if (sos_start) begin
      stub_cnt = L;
      stub_y   = sos_x + 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b1;
    in_valid = '0;
    repeat (3) step();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic drive(input int ch, input int v);
    in_valid[ch] = 1'b1;
    in_data[ch*DW +: DW] = DW'(v);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0;
    in_valid = '0;
    repeat (3) step();
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checks++;
      if (sos_start !== 1'b0 || out_valid !== 1'b0 || overrun !== '0 ||
          sos_ch !== '0 || sos_sec !== '0 || sos_x !== '0 ||
          out_ch !== '0 || out_data !== '0) begin
        errors++;
        $display("FAIL reset_outs got start=%b ov=%b ovr=%b ch=%0d sec=%0d x=%0d och=%0d od=%0d want all 0",
                 sos_start, out_valid, overrun, sos_ch, sos_sec, sos_x, out_ch, out_data);
      end
      step();
    end
  endtask

  task automatic test_single();
    exp_t e;
    logic exp_s;
    do_reset();
    step();
    drive(2, 100);
    sb.push_back('{2, 103, 14});
    for (int n = 1; n <= 20; n++) begin
      step();
      if (n == 1) in_valid = '0;
      @(negedge clk);
      exp_s = (n == 2 || n == 6 || n == 10);
      checks++;
      if (sos_start !== exp_s) begin
        errors++;
        $display("FAIL single_start cyc=%0d got %b want %b", n, sos_start, exp_s);
      end
      if (sos_start) begin
        checks++;
        if (sos_ch !== 2'd2 || sos_sec !== SW'((n - 2) / 4) || sos_x !== DW'(100 + (n - 2) / 4)) begin
          errors++;
          $display("FAIL single_cmd cyc=%0d got ch=%0d sec=%0d x=%0d want ch=2 sec=%0d x=%0d",
                   n, sos_ch, sos_sec, sos_x, (n - 2) / 4, 100 + (n - 2) / 4);
        end
      end
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL single_out got ch=%0d data=%0d want none", out_ch, out_data);
        end else begin
          e = sb.pop_front();
          if (out_ch !== CW'(e.ch) || out_data !== DW'(e.data) || n != e.cyc) begin
            errors++;
            $display("FAIL single_out got ch=%0d data=%0d cyc=%0d want ch=%0d data=%0d cyc=%0d",
                     out_ch, out_data, n, e.ch, e.data, e.cyc);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL single_missing got %0d left want 0", sb.size());
    end
  endtask

  task automatic test_all4();
    exp_t e;
    logic exp_s;
    int   ph, j;
    do_reset();
    step();
    for (int c = 0; c < CH; c++) begin
      drive(c, 10 * (c + 1));
      sb.push_back('{c, 10 * (c + 1) + 3, 14 * (c + 1)});
    end
    for (int n = 1; n <= 62; n++) begin
      step();
      if (n == 1) in_valid = '0;
      @(negedge clk);
      ph = (n - 2) % 14;
      j  = (n - 2) / 14;
      exp_s = (n >= 2 && j < CH && (ph == 0 || ph == 4 || ph == 8));
      checks++;
      if (sos_start !== exp_s) begin
        errors++;
        $display("FAIL all4_start cyc=%0d got %b want %b", n, sos_start, exp_s);
      end
      if (sos_start && exp_s) begin
        checks++;
        if (sos_ch !== CW'(j) || sos_sec !== SW'(ph / 4) || sos_x !== DW'(10 * (j + 1) + ph / 4)) begin
          errors++;
          $display("FAIL all4_cmd cyc=%0d got ch=%0d sec=%0d x=%0d want ch=%0d sec=%0d x=%0d",
                   n, sos_ch, sos_sec, sos_x, j, ph / 4, 10 * (j + 1) + ph / 4);
        end
      end
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL all4_out got ch=%0d data=%0d want none", out_ch, out_data);
        end else begin
          e = sb.pop_front();
          if (out_ch !== CW'(e.ch) || out_data !== DW'(e.data) || n != e.cyc) begin
            errors++;
            $display("FAIL all4_out got ch=%0d data=%0d cyc=%0d want ch=%0d data=%0d cyc=%0d",
                     out_ch, out_data, n, e.ch, e.data, e.cyc);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL all4_missing got %0d left want 0", sb.size());
    end
  endtask

  task automatic test_overrun();
    exp_t e;
    do_reset();
    step();
    drive(0, 50);
    sb.push_back('{0, 53, 14});
    for (int n = 1; n <= 35; n++) begin
      step();
      case (n)
        1, 4, 6: in_valid = '0;
        3: drive(1, 5);
        5: begin drive(1, 7); sb.push_back('{1, 10, 28}); end
        default: ;
      endcase
      @(negedge clk);
      if (n == 4) begin
        checks++;
        if (overrun !== 4'b0000) begin
          errors++;
          $display("FAIL ovr_first got %b want 0000", overrun);
        end
      end
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL ovr_out got ch=%0d data=%0d want none", out_ch, out_data);
        end else begin
          e = sb.pop_front();
          if (out_ch !== CW'(e.ch) || out_data !== DW'(e.data) || n != e.cyc) begin
            errors++;
            $display("FAIL ovr_out got ch=%0d data=%0d cyc=%0d want ch=%0d data=%0d cyc=%0d",
                     out_ch, out_data, n, e.ch, e.data, e.cyc);
          end
        end
      end
    end
    checks++;
    if (overrun !== 4'b0010 || sb.size() != 0) begin
      errors++;
      $display("FAIL ovr_final got ovr=%b left=%0d want ovr=0010 left=0", overrun, sb.size());
    end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    do_reset();
    step();
    drive(1, 11);
    sb.push_back('{1, 14, 14});
    for (int n = 1; n <= 32; n++) begin
      step();
      if (n == 1) begin drive(1, 22); sb.push_back('{1, 25, 28}); end
      if (n == 2) in_valid = '0;
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL same_out got ch=%0d data=%0d want none", out_ch, out_data);
        end else begin
          e = sb.pop_front();
          if (out_ch !== CW'(e.ch) || out_data !== DW'(e.data) || n != e.cyc) begin
            errors++;
            $display("FAIL same_out got ch=%0d data=%0d cyc=%0d want ch=%0d data=%0d cyc=%0d",
                     out_ch, out_data, n, e.ch, e.data, e.cyc);
          end
        end
      end
    end
    checks++;
    if (overrun !== 4'b0000 || sb.size() != 0) begin
      errors++;
      $display("FAIL same_final got ovr=%b left=%0d want ovr=0000 left=0", overrun, sb.size());
    end
  endtask

  task automatic test_rst_mid();
    exp_t e;
    logic exp_s;
    do_reset();
    step();
    drive(0, 60);
    for (int n = 1; n <= 50; n++) begin
      step();
      case (n)
        1, 31: in_valid = '0;
        8: rst = 1'b1;
        9: rst = 1'b0;
        30: begin drive(2, 70); sb.push_back('{2, 73, 44}); end
        default: ;
      endcase
      @(negedge clk);
      exp_s = (n == 2 || n == 6 || n == 32 || n == 36 || n == 40);
      checks++;
      if (sos_start !== exp_s) begin
        errors++;
        $display("FAIL rstmid_start cyc=%0d got %b want %b", n, sos_start, exp_s);
      end
      if (n == 9) begin
        checks++;
        if (sos_ch !== '0 || sos_sec !== '0 || sos_x !== '0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_clear got ch=%0d sec=%0d x=%0d ov=%b want 0", sos_ch, sos_sec, sos_x, out_valid);
        end
      end
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rstmid_out got ch=%0d data=%0d cyc=%0d want none", out_ch, out_data, n);
        end else begin
          e = sb.pop_front();
          if (out_ch !== CW'(e.ch) || out_data !== DW'(e.data) || n != e.cyc) begin
            errors++;
            $display("FAIL rstmid_out got ch=%0d data=%0d cyc=%0d want ch=%0d data=%0d cyc=%0d",
                     out_ch, out_data, n, e.ch, e.data, e.cyc);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rstmid_missing got %0d left want 0", sb.size());
    end
  endtask

  task automatic test_en_gate();
    exp_t e;
    logic exp_s;
    do_reset();
    en = 1'b0;
    step();
    drive(3, 80);
    sb.push_back('{3, 83, 24});
    for (int n = 1; n <= 62; n++) begin
      step();
      case (n)
        1, 14: in_valid = '0;
        11: en = 1'b1;
        12: en = 1'b0;
        13: drive(0, 90);
        45: begin en = 1'b1; sb.push_back('{0, 93, 58}); end
        default: ;
      endcase
      @(negedge clk);
      exp_s = (n == 12 || n == 16 || n == 20 || n == 46 || n == 50 || n == 54);
      checks++;
      if (sos_start !== exp_s) begin
        errors++;
        $display("FAIL en_start cyc=%0d got %b want %b", n, sos_start, exp_s);
      end
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL en_out got ch=%0d data=%0d cyc=%0d want none", out_ch, out_data, n);
        end else begin
          e = sb.pop_front();
          if (out_ch !== CW'(e.ch) || out_data !== DW'(e.data) || n != e.cyc) begin
            errors++;
            $display("FAIL en_out got ch=%0d data=%0d cyc=%0d want ch=%0d data=%0d cyc=%0d",
                     out_ch, out_data, n, e.ch, e.data, e.cyc);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0 || overrun !== 4'b0000) begin
      errors++;
      $display("FAIL en_final got left=%0d ovr=%b want left=0 ovr=0000", sb.size(), overrun);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all4();
    test_overrun();
    test_same_cycle();
    test_rst_mid();
    test_en_gate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
